// File: rtl/sd_regset_pkg.sv
// Shared types and constants for the SD host configuration register set.
package sd_regset_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } regset_state_e;

  localparam logic [31:0] REGSET_VERSION = 32'h0001_0000;

  // Bit i set = register index i rejects writes.
  localparam logic [63:0] RO_MASK = 64'h0000_0000_0000_0001;

  localparam int PORT_HOST = 0;
  localparam int PORT_CORE = 1;

endpackage

// File: rtl/sd_regset_arb.sv
// Two-port request arbiter with one-hot grant.
// REGSET_RR_ARB_EN selects round-robin; otherwise the host port has fixed priority.
module sd_regset_arb
  import sd_regset_pkg::*;
(
`ifdef REGSET_RR_ARB_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef REGSET_RR_ARB_EN
  logic ptr_q;
  logic ptr_d;

  // ptr_q names the port that wins a tie.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt[ptr_q] = 1'b1;
    end else begin
      gnt = req;
    end
    if (advance && (|gnt)) begin
      ptr_d = ~gnt[PORT_CORE];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_HOST]) begin
      gnt[PORT_HOST] = 1'b1;
    end else if (req[PORT_CORE]) begin
      gnt[PORT_CORE] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sd_register_set.sv
// Two-port 64x32 configuration register file with arbitrated two-cycle accesses.
// Optional round-robin arbitration via REGSET_RR_ARB_EN (fixed priority otherwise).
//
// state | meaning
// IDLE  | waiting for a request; arbitrates, performs the access, latches results
// ACK   | drives ack/err/data_out for the granted port, then returns to IDLE
module sd_register_set
  import sd_regset_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic              wnr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 2;

  regset_state_e state_q, state_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [1:0]       gnt;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             read_only;

  assign idx        = address[ADDR_W-1:2];
  assign misaligned = (address[1:0] != 2'b00);
  assign read_only  = RO_MASK[idx];

`ifdef REGSET_RR_ARB_EN
  logic advance;
  assign advance = (state_q == IDLE) && (|req);

  sd_regset_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .req     (req),
    .gnt     (gnt)
  );
`else
  sd_regset_arb u_arb (
    .req (req),
    .gnt (gnt)
  );
`endif

  always_comb begin
    state_d    = state_q;
    ack_d      = 2'b00;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    regs_d     = regs_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACK;
          ack_d   = gnt;
          if (misaligned || (wnr && read_only)) begin
            err_d      = 1'b1;
            data_out_d = '0;
          end else if (wnr) begin
            regs_d[idx] = data_in;
            data_out_d  = data_in;
          end else begin
            data_out_d = regs_q[idx];
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? DATA_W'(REGSET_VERSION) : '0;
      end
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      regs_q     <= regs_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign data_out = data_out_q;

endmodule

// File: doc/sd_register_set.md
# sd_register_set

Two-port, word-addressed 64×32 configuration register file for the SD host. It is the responder for the `req`/`wnr`/`address`/`data_in` request interface driven by the host-side and SD-core-side initiators. Simultaneous requests are arbitrated, one access is serviced per two-cycle transaction, and completion is signalled with a per-port `ack` pulse.

## Interface
Parameters:
- `ADDR_W`, 8, byte address width; register index is `address[ADDR_W-1:2]`.
- `DATA_W`, 32, register and bus data width.
- `NUM_REGS`, 64, equals `2**(ADDR_W-2)`; other combinations are unsupported.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `req`  in  2  per-port request level; bit 0 = host port, bit 1 = SD core port.
- `wnr`  in  1  1 = write, 0 = read; shared by both ports and sampled with the grant.
- `address`  in  `ADDR_W`  byte address; shared.
- `data_in`  in  `DATA_W`  write data; shared.
- `ack`  out  2  one-hot, one-cycle completion pulse to the granted port.
- `data_out`  out  `DATA_W`  read data, or the stored value after a write; valid while `ack` != 0.
- `err`  out  1  one-cycle pulse concurrent with `ack` when the access was rejected.

## Operation
- FSM has two states:
  - **IDLE**: on a rising edge with `req != 0`, the arbiter picks grant `g`. The block latches `wnr`, `address` and `data_in`, performs the access, and goes to ACK. With `req == 0` it stays in IDLE.
  - **ACK**: drives `ack[g]=1`, `data_out` and `err`, then returns to IDLE unconditionally.
- Requests are level-based. A port still holding `req` is re-arbitrated in the next IDLE cycle.
- Write (`wnr=1`): `regs[idx] <= data_in` at the IDLE edge. In ACK, `data_out` shows the new value.
- Read (`wnr=0`): `data_out <= regs[idx]` at the IDLE edge.
- Rejections assert `err=1` and `data_out=0`, and leave register contents unchanged:
  - Misaligned access: `address[1:0] != 0`.
  - Write to a read-only index, as set by `RO_MASK` in the package. Index 0 is read-only and always reads `REGSET_VERSION`.
- Simultaneous events:
  - Requests arriving while in ACK are ignored until the next IDLE cycle.
  - A `req` bit dropping during ACK does not cancel the pending `ack`.
- Outside ACK, `ack=0` and `err=0`, and `data_out` holds its last value.

## Timing
- Latency: request sampled at edge N; `ack`, `data_out` and `err` are valid in cycle N+1 and low again in cycle N+2.
- Peak throughput is one access every 2 cycles. With `req=2'b11` held continuously, grants alternate between the ports.
- Reset values while `reset=0` at an edge:
  - FSM = IDLE, `ack=0`, `err=0`, `data_out=0`.
  - All registers = 0 except index 0 (`REGSET_VERSION`).
  - Round-robin pointer = port 0.
- Reset asserted in ACK aborts the pulse: outputs are 0 in the next cycle. A write performed at the prior edge is overwritten by the reset value.
- Address wrap: none. `address` is `ADDR_W` bits and every index is in range.

## Configuration
- `REGSET_RR_ARB_EN` defined:
  - Round-robin arbitration. After each grant the pointer moves to the other port.
  - When both ports request, the port not served last wins.
  - A single requester is always granted.
- Undefined:
  - Fixed priority: port 0 always wins when both ports request.
  - The pointer flop is not built.

## Structure
- Package `sd_regset_pkg` holds:
  - The state enum `regset_state_e` {IDLE, ACK}.
  - `REGSET_VERSION` (32'h0001_0000).
  - `RO_MASK` (64-bit, bit 0 set).
  - Port index constants `PORT_HOST=0` and `PORT_CORE=1`.
- One sub-module, `sd_regset_arb`: 2-input arbiter producing a one-hot grant. It contains the round-robin pointer under `REGSET_RR_ARB_EN`.

## Test plan
- **Reset/version:** hold `reset=0` for 2 cycles, then read address 0x00 on port 0 → `ack=2'b01` one cycle later, `data_out=32'h0001_0000`, `err=0`.
- **Write/readback:**
  - Port 1 writes 32'hDEAD_BEEF to 0x10 → `ack=2'b10`, `data_out=32'hDEAD_BEEF`.
  - A read of 0x10 then returns 32'hDEAD_BEEF.
- **Errors:**
  - Write 5 to 0x06 → `err=1`, `data_out=0`; a read of 0x04 returns 0.
  - Write to 0x00 → `err=1`; the version is unchanged.
- **Contention:** hold `req=2'b11` with `wnr=1` for 8 cycles → exactly 4 `ack` pulses.
  - With `REGSET_RR_ARB_EN`: order 01, 10, 01, 10.
  - Without it: all 01.
- **Sweep:** write `$random` to addresses 0x04..0xFC in steps of 4, then read all back → every value matches and index 0 still holds the version.
- **Reset mid-access:** drop `reset` in the ACK cycle → the next cycle has `ack=0` and `data_out=0`, and the target register reads 0.
